fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC and the IF/ID register.
// Optional halt-on-HALT_INSTR state is built in when FETCH_HALT_EN is defined.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   pc             registered word address to the instruction memory
//   instruction    combinational memory read data for pc
//   stall          hold pc and IF/ID
//   redirect       load redirect_pc, flush IF/ID to a NOP bubble
//   redirect_pc    redirect target address
//   if_id_instr    captured instruction
//   if_id_pc       address of if_id_instr
//   if_id_pc_next  if_id_pc + 1 (wraps)
//   if_id_valid    IF/ID holds a real instruction
//   halted         fetch is halted (always 0 without FETCH_HALT_EN)
module fetch_unit #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [PC_WIDTH-1:0]    if_id_pc_next,
    output logic                   if_id_valid,
    output logic                   halted
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

`ifdef FETCH_HALT_EN
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
`else
    typedef enum logic {RUN = 1'b0} state_t;
`endif

    state_t                   state, state_next;
    logic [PC_WIDTH-1:0]      pc_n;
    logic [INSTR_WIDTH-1:0]   instr_n;
    logic [PC_WIDTH-1:0]      ipc_n;
    logic [PC_WIDTH-1:0]      ipcn_n;
    logic                     valid_n;
    logic                     pc_inc_valid;
    logic [PC_WIDTH-1:0]      pc_inc;

    assign pc_inc = pc + PC_ONE;
    assign pc_inc_valid = 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            if_id_instr   <= '0;
            if_id_pc      <= '0;
            if_id_pc_next <= '0;
            if_id_valid   <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_n;
            if_id_instr   <= instr_n;
            if_id_pc      <= ipc_n;
            if_id_pc_next <= ipcn_n;
            if_id_valid   <= valid_n;
        end
    end

    always_comb begin
        state_next = state;
        pc_n       = pc;
        instr_n    = if_id_instr;
        ipc_n      = if_id_pc;
        ipcn_n     = if_id_pc_next;
        valid_n    = if_id_valid;
        if (redirect) begin
            // Bubble: the fetch at the old pc is discarded; if_id_pc* hold.
            pc_n       = redirect_pc;
            instr_n    = '0;
            valid_n    = 1'b0;
            state_next = RUN;
`ifdef FETCH_HALT_EN
        end else if (state == HALT) begin
            // Halt ignores stall; IF/ID drains to invalid and pc holds.
            valid_n = 1'b0;
`endif
        end else if (stall) begin
            valid_n = if_id_valid;
        end else begin
            pc_n    = pc_inc;
            instr_n = instruction;
            ipc_n   = pc;
            ipcn_n  = pc_inc;
            valid_n = pc_inc_valid;
`ifdef FETCH_HALT_EN
            if (instruction == HALT_INSTR) begin
                state_next = HALT;
            end
`endif
        end
    end

`ifdef FETCH_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector-table and scoreboard bench for fetch_unit.
// Memory model: mem[i] = 32'h1000_0000 + i, mem[3] = halt word in halt test.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic [31:0] instruction;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_next;
    logic        if_id_valid;
    logic        halted;
    logic        halt_mode;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .instruction  (instruction),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc_next(if_id_pc_next),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (halt_mode && pc == 16'd3) instruction = 32'hFFFF_FFFF;
        else instruction = 32'h1000_0000 + {16'h0, pc};
    end

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic [15:0] e_pc;
        logic [31:0] e_instr;
        logic [15:0] e_ipc;
        logic [15:0] e_ipcn;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    vec_t exp_q[$];
    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n       = v.rst_n;
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".pc"}, {16'h0, pc}, {16'h0, e.e_pc});
            chk({tag, ".instr"}, if_id_instr, e.e_instr);
            chk({tag, ".ipc"}, {16'h0, if_id_pc}, {16'h0, e.e_ipc});
            chk({tag, ".ipcn"}, {16'h0, if_id_pc_next}, {16'h0, e.e_ipcn});
            chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e.e_valid});
            chk({tag, ".halted"}, {31'h0, halted}, {31'h0, e.e_halted});
        end
    endtask

    function automatic vec_t mk(logic r, logic s, logic rd, logic [15:0] rp,
                                logic [15:0] p, logic [31:0] i,
                                logic [15:0] ip, logic [15:0] ipn,
                                logic v, logic h);
        vec_t x;
        x.rst_n = r; x.stall = s; x.redirect = rd; x.rpc = rp;
        x.e_pc = p; x.e_instr = i; x.e_ipc = ip; x.e_ipcn = ipn;
        x.e_valid = v; x.e_halted = h;
        return x;
    endfunction

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        halt_mode = 1'b0;

        // reset, then free run, stall, redirect with stall, wrap
        vt[0]  = mk(1,0,0,16'h0, 16'h1, 32'h1000_0000, 16'h0, 16'h1, 1,0);
        vt[1]  = mk(1,0,0,16'h0, 16'h2, 32'h1000_0001, 16'h1, 16'h2, 1,0);
        vt[2]  = mk(1,0,0,16'h0, 16'h3, 32'h1000_0002, 16'h2, 16'h3, 1,0);
        vt[3]  = mk(1,0,0,16'h0, 16'h4, 32'h1000_0003, 16'h3, 16'h4, 1,0);
        vt[4]  = mk(1,0,0,16'h0, 16'h5, 32'h1000_0004, 16'h4, 16'h5, 1,0);
        vt[5]  = mk(1,1,0,16'h0, 16'h5, 32'h1000_0004, 16'h4, 16'h5, 1,0);
        vt[6]  = mk(1,1,0,16'h0, 16'h5, 32'h1000_0004, 16'h4, 16'h5, 1,0);
        vt[7]  = mk(1,0,0,16'h0, 16'h6, 32'h1000_0005, 16'h5, 16'h6, 1,0);
        vt[8]  = mk(1,1,1,16'hA, 16'hA, 32'h0,         16'h5, 16'h6, 0,0);
        vt[9]  = mk(1,0,0,16'h0, 16'hB, 32'h1000_000A, 16'hA, 16'hB, 1,0);
        vt[10] = mk(1,0,1,16'hFFFF,16'hFFFF,32'h0,     16'hA, 16'hB, 0,0);
        vt[11] = mk(1,0,0,16'h0, 16'h0, 32'h1000_FFFF, 16'hFFFF,16'h0,1,0);
        vt[12] = mk(1,0,0,16'h0, 16'h1, 32'h1000_0000, 16'h0, 16'h1, 1,0);

        step("rst0", mk(0,0,0,16'h0, 16'h0, 32'h0, 16'h0, 16'h0, 0,0));
        step("rst1", mk(0,1,1,16'h5, 16'h0, 32'h0, 16'h0, 16'h0, 0,0));
        for (int i = 0; i < 13; i++) begin
            step($sformatf("v%0d", i), vt[i]);
        end

        // reset wins over stall and redirect mid-run
        step("mrst", mk(0,1,1,16'h7, 16'h0, 32'h0, 16'h0, 16'h0, 0,0));
        step("mrst1", mk(1,0,0,16'h0, 16'h1, 32'h1000_0000, 16'h0, 16'h1, 1,0));

`ifdef FETCH_HALT_EN
        step("hrst", mk(0,0,0,16'h0, 16'h0, 32'h0, 16'h0, 16'h0, 0,0));
        halt_mode = 1'b1;
        step("h0", mk(1,0,0,16'h0, 16'h1, 32'h1000_0000, 16'h0, 16'h1, 1,0));
        step("h1", mk(1,0,0,16'h0, 16'h2, 32'h1000_0001, 16'h1, 16'h2, 1,0));
        step("h2", mk(1,0,0,16'h0, 16'h3, 32'h1000_0002, 16'h2, 16'h3, 1,0));
        step("hcap", mk(1,0,0,16'h0, 16'h4, 32'hFFFF_FFFF, 16'h3, 16'h4, 1,1));
        step("hold", mk(1,0,0,16'h0, 16'h4, 32'hFFFF_FFFF, 16'h3, 16'h4, 0,1));
        step("hstl", mk(1,1,0,16'h0, 16'h4, 32'hFFFF_FFFF, 16'h3, 16'h4, 0,1));
        step("hred", mk(1,1,1,16'h0, 16'h0, 32'h0, 16'h3, 16'h4, 0,0));
        step("hrun", mk(1,0,0,16'h0, 16'h1, 32'h1000_0000, 16'h0, 16'h1, 1,0));
        step("hr2", mk(1,0,0,16'h0, 16'h2, 32'h1000_0001, 16'h1, 16'h2, 1,0));
        step("hmrst", mk(0,0,0,16'h0, 16'h0, 32'h0, 16'h0, 16'h0, 0,0));
        halt_mode = 1'b0;
`else
        // halt word is an ordinary instruction in this build
        halt_mode = 1'b1;
        step("nh0", mk(1,0,1,16'h3, 16'h3, 32'h0, 16'h0, 16'h1, 0,0));
        step("nh1", mk(1,0,0,16'h0, 16'h4, 32'hFFFF_FFFF, 16'h3, 16'h4, 1,0));
        step("nh2", mk(1,0,0,16'h0, 16'h5, 32'h1000_0004, 16'h4, 16'h5, 1,0));
        halt_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
